// File: rtl/sd_wb_burst_sel_gen_pkg.sv
// Shared types and width helpers for the SD Wishbone burst address/select sequencer.
package sd_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Width of the byte-within-word offset for a given bus width in bits.
  function automatic int ofs_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sd_wb_lane_mask.sv
// Byte-lane enable mask for lanes lo..hi inclusive.
// Lane order is big-endian unless SD_WB_SEL_LITTLE_ENDIAN_EN is defined.
module sd_wb_lane_mask
  import sd_wb_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [ofs_width(BYTES*8)-1:0] lo,
  input  logic [ofs_width(BYTES*8)-1:0] hi,
  output logic [BYTES-1:0]              mask
);

  localparam int OFS_W = ofs_width(BYTES * 8);

  always_comb begin
    mask = '0;
    for (int k = 0; k < BYTES; k++) begin
      if ((OFS_W'(k) >= lo) && (OFS_W'(k) <= hi)) begin
`ifdef SD_WB_SEL_LITTLE_ENDIAN_EN
        mask[k] = 1'b1;
`else
        mask[BYTES-1-k] = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/sd_wb_burst_sel_gen.sv
// Wishbone master address / byte-select sequencer for the SD DMA data path.
// Lane order follows sd_wb_lane_mask (SD_WB_SEL_LITTLE_ENDIAN_EN selects little-endian).
module sd_wb_burst_sel_gen
  import sd_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 32,
  parameter int SIZE_W = 12
) (
  input  logic                wb_clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADR_W-1:0]    base_adr_i,
  input  logic [SIZE_W-1:0]   xfersize_i,
  input  logic                beat_ack_i,
  output logic [ADR_W-1:0]    wbm_adr_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic                wbm_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int              BYTES   = DATA_W / 8;
  localparam int              OFS_W   = ofs_width(DATA_W);
  localparam logic [SIZE_W:0] BYTES_R = (SIZE_W+1)'(BYTES);

  state_t            state_q, state_n;
  logic [OFS_W-1:0]  ofs_q, ofs_n;
  logic [SIZE_W:0]   rem_q, rem_n;
  logic [ADR_W-1:0]  adr_n;
  logic [OFS_W-1:0]  hi_n;
  logic [BYTES-1:0]  mask_n;

  // Next-beat values; outputs are registered from these so they appear one cycle later.
  always_comb begin
    state_n = state_q;
    ofs_n   = ofs_q;
    rem_n   = rem_q;
    adr_n   = wbm_adr_o;
    case (state_q)
      ST_ACTIVE: begin
        if (abort_i) begin
          state_n = ST_IDLE;
        end else if (beat_ack_i) begin
          if (wbm_last_o) begin
            state_n = ST_DONE;
          end else begin
            adr_n = wbm_adr_o + ADR_W'(BYTES);
            rem_n = rem_q - BYTES_R;
            ofs_n = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        if (start_i) begin
          ofs_n   = base_adr_i[OFS_W-1:0];
          adr_n   = {base_adr_i[ADR_W-1:OFS_W], {OFS_W{1'b0}}};
          rem_n   = (SIZE_W+1)'(base_adr_i[OFS_W-1:0]) + (SIZE_W+1)'(xfersize_i);
          state_n = (xfersize_i == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
    endcase
    hi_n = (rem_n >= BYTES_R) ? OFS_W'(BYTES - 1) : (rem_n[OFS_W-1:0] - OFS_W'(1));
  end

  sd_wb_lane_mask #(
    .BYTES (BYTES)
  ) u_lane_mask (
    .lo   (ofs_n),
    .hi   (hi_n),
    .mask (mask_n)
  );

  // Control and output registers
  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wbm_adr_o  <= '0;
      wbm_sel_o  <= '1;
      wbm_last_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_n;
      wbm_adr_o  <= adr_n;
      wbm_sel_o  <= (state_n == ST_ACTIVE) ? mask_n : '1;
      wbm_last_o <= (state_n == ST_ACTIVE) && (rem_n <= BYTES_R);
      busy_o     <= (state_n == ST_ACTIVE);
      done_o     <= (state_n == ST_DONE);
    end
  end

  // Transfer bookkeeping carries no reset; it is always loaded by start_i before use.
  always_ff @(posedge wb_clk) begin
    ofs_q <= ofs_n;
    rem_q <= rem_n;
  end

endmodule

// File: tb/tb_sd_wb_burst_sel_gen.sv
// Bench for sd_wb_burst_sel_gen: 32- and 64-bit instances against a byte-walk reference model.
module tb_sd_wb_burst_sel_gen;

`ifdef SD_WB_SEL_LITTLE_ENDIAN_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i, beat_ack_i;
  logic [31:0] base_adr_i;
  logic [11:0] xfersize_i;

  logic [31:0] adr32, adr64;
  logic [3:0]  sel32;
  logic [7:0]  sel64;
  logic        last32, busy32, done32, last64, busy64, done64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sd_wb_burst_sel_gen #(.DATA_W(32), .ADR_W(32), .SIZE_W(12)) u_dut32 (
    .wb_clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_adr_i(base_adr_i), .xfersize_i(xfersize_i), .beat_ack_i(beat_ack_i),
    .wbm_adr_o(adr32), .wbm_sel_o(sel32), .wbm_last_o(last32),
    .busy_o(busy32), .done_o(done32)
  );

  sd_wb_burst_sel_gen #(.DATA_W(64), .ADR_W(32), .SIZE_W(12)) u_dut64 (
    .wb_clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_adr_i(base_adr_i), .xfersize_i(xfersize_i), .beat_ack_i(beat_ack_i),
    .wbm_adr_o(adr64), .wbm_sel_o(sel64), .wbm_last_o(last64),
    .busy_o(busy64), .done_o(done64)
  );

  // Reference model: per instance, the list of beats obtained by walking every byte of the transfer.
  logic [31:0] m_adr [2][0:31];
  logic [7:0]  m_sel [2][0:31];
  int          m_n [2];
  int          m_idx [2];
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_adr_chk [2];

  function automatic int bytes_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  task automatic build(input int i, input logic [31:0] base, input int size);
    m_n[i] = 0;
    for (int a = 0; a < size; a++) begin
      logic [31:0] b;
      logic [31:0] w;
      int          lane;
      int          bi;
      b    = base + 32'(a);
      lane = int'(b % 32'(bytes_of(i)));
      w    = b - 32'(lane);
      if (m_n[i] == 0 || m_adr[i][m_n[i]-1] != w) begin
        m_adr[i][m_n[i]] = w;
        m_sel[i][m_n[i]] = 8'h00;
        m_n[i]++;
      end
      bi = LE ? lane : (bytes_of(i) - 1 - lane);
      m_sel[i][m_n[i]-1][bi] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_adr_chk[i] = 1'b1;
      end else if (m_busy[i]) begin
        m_done[i] = 1'b0;
        if (abort_i) begin
          m_busy[i] = 1'b0;
        end else if (beat_ack_i) begin
          if (m_idx[i] == m_n[i] - 1) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1;
          end else begin
            m_idx[i]++;
          end
        end
      end else begin
        m_done[i] = 1'b0;
        if (start_i) begin
          m_adr_chk[i] = 1'b0;
          build(i, base_adr_i, int'(xfersize_i));
          m_idx[i] = 0;
          if (xfersize_i == 12'd0) m_done[i] = 1'b1;
          else m_busy[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [31:0] adr, input logic [7:0] sel,
                            input logic last, input logic busy, input logic done);
    logic [7:0] ones;
    string      s;
    ones = (i == 0) ? 8'h0f : 8'hff;
    s    = (i == 0) ? "32" : "64";
    chk({"busy", s}, 64'(busy), 64'(m_busy[i]));
    chk({"done", s}, 64'(done), 64'(m_done[i]));
    chk({"sel", s}, 64'(sel), m_busy[i] ? 64'(m_sel[i][m_idx[i]]) : 64'(ones));
    chk({"last", s}, 64'(last), 64'(m_busy[i] && (m_idx[i] == m_n[i] - 1)));
    if (m_busy[i]) chk({"adr", s}, 64'(adr), 64'(m_adr[i][m_idx[i]]));
    else if (m_adr_chk[i]) chk({"rstadr", s}, 64'(adr), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_inst(0, adr32, {4'h0, sel32}, last32, busy32, done32);
    check_inst(1, adr64, sel64, last64, busy64, done64);
  endtask

  task automatic go(input logic [31:0] base, input logic [11:0] size);
    start_i = 1'b1; base_adr_i = base; xfersize_i = size;
    tick();
    start_i = 1'b0;
  endtask

  task automatic drain();
    start_i = 1'b0; abort_i = 1'b0; beat_ack_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!m_busy[0] && !m_busy[1] && !m_done[0] && !m_done[1]) break;
      tick();
    end
    beat_ack_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_adr_chk[i] = 1'b1; m_n[i] = 0; m_idx[i] = 0;
    end
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; beat_ack_i = 1'b0;
    base_adr_i = '0; xfersize_i = '0;
    tick(); tick();
    chk("rst_sel32", 64'(sel32), 64'h0f);
    chk("rst_sel64", 64'(sel64), 64'hff);
    rst = 1'b0;
    tick();

    // base 11, size 2, ack every beat
    go(32'd11, 12'd2);
    chk("t1_adr1", 64'(adr32), 64'd8);
    chk("t1_sel1", 64'(sel32), LE ? 64'h8 : 64'h1);
    chk("t1_last1", 64'(last32), 64'd0);
    beat_ack_i = 1'b1;
    tick();
    chk("t1_adr2", 64'(adr32), 64'd12);
    chk("t1_sel2", 64'(sel32), LE ? 64'h1 : 64'h8);
    chk("t1_last2", 64'(last32), 64'd1);
    tick();
    chk("t1_done", 64'(done32), 64'd1);
    chk("t1_self", 64'(sel32), 64'hf);
    drain();

    // base 101, size 19
    go(32'd101, 12'd19);
    chk("t2_adr0", 64'(adr32), 64'd100);
    chk("t2_sel0", 64'(sel32), LE ? 64'he : 64'h7);
    beat_ack_i = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tick();
      chk("t2_adr", 64'(adr32), 64'(100 + 4 * b));
      chk("t2_sel", 64'(sel32), 64'hf);
      chk("t2_last", 64'(last32), 64'(b == 4));
    end
    tick();
    chk("t2_done", 64'(done32), 64'd1);
    tick();
    chk("t2_done_once", 64'(done32), 64'd0);
    drain();

    // base 52, size 5, ack withheld for 3 cycles
    go(32'd52, 12'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_hold_adr", 64'(adr32), 64'd52);
      chk("t3_hold_sel", 64'(sel32), 64'hf);
    end
    beat_ack_i = 1'b1;
    tick();
    chk("t3_adr", 64'(adr32), 64'd56);
    chk("t3_sel", 64'(sel32), LE ? 64'h1 : 64'h8);
    chk("t3_last", 64'(last32), 64'd1);
    drain();

    // 64-bit lanes
    go(32'd3, 12'd2);
    chk("t4_adr64", 64'(adr64), 64'd0);
    chk("t4_sel64", 64'(sel64), 64'h18);
    chk("t4_last64", 64'(last64), 64'd1);
    drain();
    go(32'd1, 12'd1);
    chk("t4_sel64b", 64'(sel64), LE ? 64'h02 : 64'h40);
    chk("t4_sel32b", 64'(sel32), LE ? 64'h2 : 64'h4);
    drain();

    // zero-length transfer, then abort colliding with ack
    go(32'd20, 12'd0);
    chk("t5_busy", 64'(busy32), 64'd0);
    chk("t5_done", 64'(done32), 64'd1);
    tick();
    go(32'd0, 12'd16);
    beat_ack_i = 1'b1;
    tick();
    abort_i = 1'b1;
    tick();
    chk("t5_abort_busy", 64'(busy32), 64'd0);
    chk("t5_abort_done", 64'(done32), 64'd0);
    abort_i = 1'b0; beat_ack_i = 1'b0;
    tick();
    chk("t5_abort_nodone", 64'(done32), 64'd0);

    // reset during beat 2, then a fresh start
    go(32'd0, 12'd8);
    beat_ack_i = 1'b1;
    tick();
    rst = 1'b1; beat_ack_i = 1'b0;
    tick();
    chk("t6_adr", 64'(adr32), 64'd0);
    chk("t6_busy", 64'(busy32), 64'd0);
    chk("t6_last", 64'(last32), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_nodone", 64'(done32), 64'd0);
    go(32'd44, 12'd9);
    chk("t6_restart", 64'(busy32), 64'd1);
    drain();

    // address wrap
    go(32'hFFFF_FFFE, 12'd6);
    drain();

    // randomized transfers with random ack/abort and start attempts while busy
    repeat (40) begin
      abort_i = 1'b0; beat_ack_i = 1'b0;
      go($urandom, ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 100)));
      for (int c = 0; c < 80; c++) begin
        beat_ack_i = ($urandom_range(0, 3) != 0);
        abort_i    = ($urandom_range(0, 49) == 0);
        start_i    = ($urandom_range(0, 9) == 0);
        base_adr_i = $urandom;
        xfersize_i = 12'($urandom_range(0, 100));
        tick();
        if (!m_busy[0] && !m_busy[1] && !m_done[0] && !m_done[1]) break;
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
